sipo_deser: RTL and testbench
=============================

# sipo_deser

Serial-in/parallel-out deserializer that consumes the single-bit stream produced by the mux-built d-latch/flop stage. It assembles `WIDTH` qualified bits into a word and presents the word on a valid/ready output handshake. A one-word holding register and a sticky overrun flag sit on the output. An optional parity bit follows each word.

## Interface
- `WIDTH`, 8: data bits per word (≥2).
- `MSB_FIRST`, 1: 1 means the first received bit lands in `out_data[WIDTH-1]`; 0 means it lands in `out_data[0]`.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `din` input 1: serial data bit from the upstream latch stage.
- `din_en` input 1: `din` is sampled only on edges where this is 1.
- `clr` input 1: synchronous clear of the partial word and `overrun`.
- `out_data` output `WIDTH`: assembled word (holding register).
- `out_valid` output 1: holding register contains an untransferred word.
- `out_ready` input 1: consumer accepts the word when `out_valid && out_ready`.
- `busy` output 1: a partial word is in progress (bit count ≠ 0 or in parity phase).
- `overrun` output 1: sticky; a completed word was dropped because the holding register was full.
- `par_err` output 1: parity result for the word in `out_data`. Tied 0 unless `SIPO_PARITY_EN`.

## Operation
- Reset value of every output is 0 (`out_data`, `out_valid`, `busy`, `overrun`, `par_err`). Internal shift register, bit counter and FSM are also cleared. Reset asserted mid-word discards the partial word.
- FSM states:
  - `S_DATA`: collect data bits.
  - `S_PAR`: collect the parity bit (exists only with `SIPO_PARITY_EN`).
- In `S_DATA`, each `din_en` edge shifts `din` in and increments the bit counter (0..`WIDTH-1`).
- On the edge sampling bit `WIDTH`, the word is complete:
  - Without parity: the word is committed and the counter returns to 0.
  - With parity: the FSM goes to `S_PAR`; the next `din_en` bit is parity. The word is committed on that edge and the FSM returns to `S_DATA`.
- Commit rules:
  - Holding register empty, or being emptied on the same edge (`out_valid && out_ready`): load `out_data`; `out_valid`=1.
  - Otherwise: drop the new word, keep the old one, set `overrun`=1.
- Handshake:
  - `out_data` and `par_err` are stable while `out_valid && !out_ready`.
  - A transfer with no simultaneous commit clears `out_valid` on that edge.
- `clr`=1:
  - Resets the counter and FSM to `S_DATA` and clears `overrun`.
  - Has priority over `din_en`; a bit presented on that edge is discarded.
  - Does not touch `out_data`, `out_valid` or `par_err`.
- `out_ready` while `out_valid`=0 has no effect.

## Timing
- Latency: `out_valid` rises on the same edge that samples the last bit of the word (the parity bit when enabled). It is visible in the following cycle.
- Throughput: one bit per cycle at most. `din_en` may be held high continuously; words are back-to-back with no gap bit.
- Gaps (`din_en`=0) may occur anywhere in a word with no effect other than delay.
- `busy` is registered. It is 1 from the edge after the first bit of a word up to and including the commit edge, then 0.

## Configuration
- `SIPO_PARITY_EN` defined:
  - Adds `S_PAR`; each word is `WIDTH`+1 bits.
  - Even parity: `par_err`=1 when XOR of the data bits and the parity bit is 1.
  - `par_err` is loaded together with `out_data`; it is not sticky.
  - A word with a parity error is still delivered.
- Not defined: no parity phase; `par_err` is constant 0.

## Structure
- Package `sipo_pkg`:
  - FSM state enum (`S_DATA`, `S_PAR`).
  - Counter-width constant via `$clog2(WIDTH+1)`.
- One sub-module, `sipo_shift_core`: shift register plus bit counter and word-complete pulse. The top level holds the FSM, holding register, handshake and flags.

## Test plan
- Reset and MSB-first: `WIDTH`=8, `MSB_FIRST`=1, `out_ready`=1. Stream 1,0,1,0,0,1,0,1 with `din_en`=1.
  - Required: `out_valid` high for exactly one cycle after the 8th sample, with `out_data`=8'hA5. `overrun`=0.
- Bit order: stream 1,1,0,0,0,0,0,0.
  - Required: `MSB_FIRST`=1 gives 8'hC0; `MSB_FIRST`=0 gives 8'h03.
- Backpressure: `out_ready`=0. Send 8'hC0, then 8'h3C.
  - Required: `out_data` stays 8'hC0 and `overrun`=1 after bit 16. Raising `out_ready` transfers 8'hC0, then `out_valid`=0. `clr` pulse sets `overrun`=0.
- Simultaneous events: with 8'hC0 held, assert `out_ready` on the edge sampling the last bit of 8'h3C.
  - Required: `out_valid` stays 1, `out_data`=8'h3C, `overrun`=0.
- Reset/clear mid-word: 4 bits, then `rst_n`=0 for 1 cycle (repeat with `clr`=1 plus `din_en`=1). Then 8 bits 8'h81.
  - Required: after reset, all outputs are 0. Next word is exactly 8'h81; the `clr`-edge bit is not included.
- Parity (`SIPO_PARITY_EN`): 8'hC0 followed by parity 0.
  - Required: `par_err`=0.
  - Then 8'hC0 followed by parity 1: `par_err`=1, with `out_valid` after the 9th bit.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the sipo_deser serial-to-parallel deserializer.
package sipo_pkg;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_e;

  // Bit counter width, sized with headroom so WIDTH itself is representable.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; flags the edge on which the WIDTH-th data bit lands.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_done_o,
  output logic             busy_o
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (shift_en_i) begin
      shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], din_i} : {din_i, shift_q[WIDTH-1:1]};
      cnt_d   = last_bit ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // word_o is the post-edge word, so the top can commit on the completing edge;
  // while shifting is paused it simply presents the held word.
  assign word_o      = shift_d;
  assign word_done_o = shift_en_i && !clr_i && last_bit;
  assign busy_o      = (cnt_q != '0);

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with one-word holding register and sticky overrun.
// Define SIPO_PARITY_EN to append an even-parity bit to every word and report par_err.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_en,
  input  logic             clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             par_err
);

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             core_busy;
  logic             shift_en;
  logic             commit;
  logic             commit_par;

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovr_q;
  logic             par_q;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .shift_en_i (shift_en),
    .din_i      (din),
    .word_o     (word),
    .word_done_o(word_done),
    .busy_o     (core_busy)
  );

`ifdef SIPO_PARITY_EN
  state_e state_q;

  // In S_PAR the core is frozen, so word is the completed data word.
  assign shift_en   = din_en && (state_q == S_DATA);
  assign commit     = din_en && !clr && (state_q == S_PAR);
  assign commit_par = ^{word, din};
  assign busy       = core_busy || (state_q == S_PAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DATA;
    end else if (clr) begin
      state_q <= S_DATA;
    end else begin
      case (state_q)
        S_DATA:  if (word_done) state_q <= S_PAR;
        S_PAR:   if (din_en)    state_q <= S_DATA;
        default: state_q <= S_DATA;
      endcase
    end
  end
`else
  assign shift_en   = din_en;
  assign commit     = word_done;
  assign commit_par = 1'b0;
  assign busy       = core_busy;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      if (commit) begin
        // A same-edge transfer frees the slot for the new word.
        if (!valid_q || out_ready) begin
          data_q  <= word;
          par_q   <= commit_par;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
      if (clr) ovr_q <= 1'b0;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign par_err   = par_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed scenarios plus randomized traffic vs a bit-queue model.
module tb_sipo_deser;

  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = W + PAR;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         din_en = 1'b0;
  logic         clr = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data, out_data_l;
  logic         out_valid, out_valid_l;
  logic         busy, busy_l, overrun, overrun_l, par_err, par_err_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .par_err(par_err)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .clr(clr),
    .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .busy(busy_l), .overrun(overrun_l), .par_err(par_err_l)
  );

  // Reference model: a queue of received bits, assembled into a word once full.
  bit           mbits[$];
  logic         m_valid, m_ovr, m_par;
  logic [W-1:0] m_data, m_data_l;

  task automatic model_reset();
    mbits.delete();
    m_valid = 0; m_ovr = 0; m_par = 0; m_data = '0; m_data_l = '0;
  endtask

  task automatic model_step();
    logic         xfer, commit, p;
    logic [W-1:0] wm, wl;
    xfer = m_valid && out_ready;
    commit = 0; wm = '0; wl = '0; p = 0;
    if (!clr && din_en) begin
      mbits.push_back(din);
      if (mbits.size() == NB) begin
        commit = 1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = mbits[i];
          wl[i]     = mbits[i];
        end
        for (int i = 0; i < NB; i++) p = p ^ mbits[i];
        if (PAR == 0) p = 0;
        mbits.delete();
      end
    end
    if (clr) mbits.delete();
    if (commit) begin
      if (!m_valid || xfer) begin
        m_data = wm; m_data_l = wl; m_par = p; m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (xfer) begin
      m_valid = 0;
    end
    if (clr) m_ovr = 0;
  endtask

  task automatic step(input logic en, input logic d, input logic rdy, input logic c);
    @(negedge clk);
    din_en = en; din = d; out_ready = rdy; clr = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_en = 0; din = 0; out_ready = 0; clr = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Streams w MSB first (so dut_m sees w), then the parity bit when enabled.
  task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic rdy_last,
                           input logic bad_par);
    logic b;
    for (int i = 0; i < NB; i++) begin
      b = (i < W) ? w[W-1-i] : (^w) ^ bad_par;
      step(1'b1, b, (i == NB - 1) ? rdy_last : rdy, 1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({out_data, out_valid, busy, overrun, par_err} !== {8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL reset_outputs got data=%h v=%b b=%b o=%b p=%b want all 0",
               out_data, out_valid, busy, overrun, par_err);
    end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] w;
    w = 8'hA5;
    do_reset();
    for (int i = 0; i < NB - 1; i++) step(1'b1, (i < W) ? w[W-1-i] : ^w, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL msb_pre_last got v=%b busy=%b want v=0 busy=1", out_valid, busy);
    end
    step(1'b1, (NB == W) ? w[0] : ^w, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || overrun !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL msb_word got v=%b data=%h o=%b busy=%b want v=1 data=a5 o=0 busy=0",
               out_valid, out_data, overrun, busy);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL msb_one_cycle got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_bit_order();
    do_reset();
    send_word(8'hC0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_data !== 8'hC0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL order_msb got data=%h v=%b want c0 v=1", out_data, out_valid);
    end
    checks++;
    if (out_data_l !== 8'h03 || out_valid_l !== 1'b1) begin
      failures++;
      $display("FAIL order_lsb got data=%h v=%b want 03 v=1", out_data_l, out_valid_l);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    do_reset();
    send_word(8'hC0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hC0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL bp_first got v=%b data=%h o=%b want v=1 c0 o=0", out_valid, out_data, overrun);
    end
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hC0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL bp_overrun got v=%b data=%h o=%b want v=1 c0 o=1", out_valid, out_data, overrun);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain got v=%b o=%b want v=0 o=1", out_valid, overrun);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b0 || out_data !== 8'hC0) begin
      failures++;
      $display("FAIL bp_clr got o=%b data=%h want o=0 data=c0", overrun, out_data);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_word(8'hC0, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || overrun !== 1'b0) begin
      failures++;
      $display("FAIL simul got v=%b data=%h o=%b want v=1 3c o=0", out_valid, out_data, overrun);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_midword_abort();
    do_reset();
    send_word(8'hFF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    #1;
    checks++;
    if ({out_data, out_valid, busy, overrun, par_err} !== {8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL abort_reset got data=%h v=%b b=%b o=%b p=%b want all 0",
               out_data, out_valid, busy, overrun, par_err);
    end
    send_word(8'h81, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_data !== 8'h81 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_rst_word got data=%h v=%b want 81 v=1", out_data, out_valid);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_clr_busy got %b want 0", busy);
    end
    send_word(8'h81, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_data !== 8'h81 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_clr_word got data=%h v=%b want 81 v=1", out_data, out_valid);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    do_reset();
    send_word(8'hC0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (par_err !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL par_good got p=%b v=%b want p=0 v=1", par_err, out_valid);
    end
    for (int i = 0; i < W; i++) step(1'b1, (i < 2) ? 1'b1 : 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL par_wait got v=%b busy=%b want v=0 busy=1", out_valid, busy);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (par_err !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hC0) begin
      failures++;
      $display("FAIL par_bad got p=%b v=%b data=%h want p=1 v=1 c0", par_err, out_valid, out_data);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic en, d, rdy, c;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      en  = ($urandom_range(0, 3) != 0);
      d   = $urandom_range(0, 1);
      rdy = ($urandom_range(0, 2) != 0);
      c   = ($urandom_range(0, 63) == 0);
      step(en, d, rdy, c);
      checks++;
      if ({out_valid, out_data, overrun, busy, par_err} !==
          {m_valid, m_data, m_ovr, (mbits.size() != 0), m_par}) begin
        failures++;
        $display("FAIL rand_msb cyc=%0d got v=%b d=%h o=%b b=%b p=%b want v=%b d=%h o=%b b=%b p=%b",
                 n, out_valid, out_data, overrun, busy, par_err,
                 m_valid, m_data, m_ovr, (mbits.size() != 0), m_par);
      end
      checks++;
      if ({out_valid_l, out_data_l, overrun_l} !== {m_valid, m_data_l, m_ovr}) begin
        failures++;
        $display("FAIL rand_lsb cyc=%0d got v=%b d=%h o=%b want v=%b d=%h o=%b",
                 n, out_valid_l, out_data_l, overrun_l, m_valid, m_data_l, m_ovr);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_msb_first();
    test_bit_order();
    test_backpressure();
    test_simultaneous();
    test_midword_abort();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
